prog_counter_gen2: RTL and testbench

- Parametrised successor to the team's 8-bit loadable up-counter.
- Adds generic width, a programmable prescaler, up/down direction, a programmable terminal limit, wrap/saturate/one-shot modes, a terminal-count pulse and a compare-match flag.
- Sits behind the chip-level pin mapping as a reusable timer/counter core.
- Output gating matches the existing convention: outputs are forced to 0, never Z.

---
 rtl/prog_counter_gen2_pkg.sv | 7 +
 rtl/prog_counter_gen2_if.sv | 24 ++
 rtl/prog_counter_gen2_prescaler.sv | 16 +
 rtl/prog_counter_gen2.sv | 60 ++++++
 tb/tb_prog_counter_gen2.sv | 125 ++++++++++++
 5 files changed

// File: rtl/prog_counter_gen2_pkg.sv
// prog_counter_pkg: mode encodings and one-shot FSM states for prog_counter_gen2
package prog_counter_pkg;
    localparam logic [1:0] MODE_WRAP    = 2'b00;
    localparam logic [1:0] MODE_SAT     = 2'b01;
    localparam logic [1:0] MODE_ONESHOT = 2'b10;
    typedef enum logic {ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/prog_counter_gen2_if.sv
// prog_counter_gen2_if: control inputs and status outputs of the counter core
interface prog_counter_gen2_if #(parameter int WIDTH = 8, parameter int PRESC_W = 4);
    logic               en;
    logic               load;
    logic [WIDTH-1:0]   load_val;
    logic               dir;
    logic [1:0]         mode;
    logic [WIDTH-1:0]   limit;
    logic [PRESC_W-1:0] presc;
    logic [WIDTH-1:0]   cmp_val;
    logic               oe;
    logic [WIDTH-1:0]   count_out;
    logic               tc;
    logic               cmp_match;
    logic               done;
    modport master (
        output en, load, load_val, dir, mode, limit, presc, cmp_val, oe,
        input  count_out, tc, cmp_match, done
    );
    modport slave (
        input  en, load, load_val, dir, mode, limit, presc, cmp_val, oe,
        output count_out, tc, cmp_match, done
    );
endinterface

// File: rtl/prog_counter_gen2_prescaler.sv
// prog_prescaler: divides enabled cycles by presc+1 into single-cycle ticks
module prog_prescaler #(parameter int PRESC_W = 4) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);
    logic [PRESC_W-1:0] r_pcnt;
    assign tick = en && !clr && (r_pcnt == presc);
    always_ff @(posedge clk) begin
        if (rst || clr) r_pcnt <= '0;
        else if (en) r_pcnt <= tick ? '0 : r_pcnt + PRESC_W'(1);
    end
endmodule

// File: rtl/prog_counter_gen2.sv
// prog_counter_gen2: prescaled up/down counter with limit, wrap/saturate/one-shot
// modes, terminal-count pulse and compare flag
module prog_counter_gen2
    import prog_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int PRESC_W = 4
) (
    input logic               clk,
    input logic               rst,
    prog_counter_gen2_if.slave bus
);
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    state_t           r_state, w_state_nxt;
    logic             r_tc, w_pre_tick, w_tick, w_term, w_run_tick;

    prog_prescaler #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .clr   (bus.load),
        .presc (bus.presc),
        .tick  (w_pre_tick)
    );

    assign w_tick     = w_pre_tick && !bus.load;
    assign w_term     = bus.dir ? (r_cnt >= bus.limit) : (r_cnt == '0);
    assign w_run_tick = w_tick && (r_state == ST_RUN);

    // Ticks arriving in DONE are dropped; leaving DONE on a mode change costs one edge
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        if (r_state == ST_DONE) w_state_nxt = (bus.mode != MODE_ONESHOT) ? ST_RUN : ST_DONE;
        else if (w_run_tick && w_term && bus.mode == MODE_ONESHOT) w_state_nxt = ST_DONE;
        if (w_run_tick && !w_term) w_cnt_nxt = bus.dir ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
        else if (w_run_tick && bus.mode != MODE_SAT && bus.mode != MODE_ONESHOT) w_cnt_nxt = bus.dir ? '0 : bus.limit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_tc    <= 1'b0;
            r_state <= ST_RUN;
        end else if (bus.load) begin
            r_cnt   <= bus.load_val;
            r_tc    <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_run_tick && w_term;
            r_state <= w_state_nxt;
        end
    end

    assign bus.count_out = bus.oe ? r_cnt : '0;
    assign bus.tc        = r_tc;
    assign bus.cmp_match = (r_cnt == bus.cmp_val);
    assign bus.done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_prog_counter_gen2.sv
// tb_prog_counter_gen2: directed vectors with a queued scoreboard for prog_counter_gen2
module tb_prog_counter_gen2;
    typedef struct {
        string      nm;
        logic [7:0] c;
        logic       t;
        logic       d;
        logic       m;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t q[$];
    int   vecs = 0;
    int   miss = 0;

    prog_counter_gen2_if #(.WIDTH(8), .PRESC_W(4)) bus ();
    prog_counter_gen2 #(.WIDTH(8), .PRESC_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] c, input logic t, input logic d, input logic m);
        exp_t e;
        @(posedge clk);
        #1;
        e.nm = nm; e.c = c; e.t = t; e.d = d; e.m = m;
        q.push_back(e);
        #4;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            while (q.size() > 0) begin
                e = q.pop_front();
                vecs++;
                if (bus.count_out !== e.c || bus.tc !== e.t || bus.done !== e.d || bus.cmp_match !== e.m) begin
                    miss++;
                    $display("FAIL %s: got cnt=%02h tc=%b done=%b cm=%b, want cnt=%02h tc=%b done=%b cm=%b",
                             e.nm, bus.count_out, bus.tc, bus.done, bus.cmp_match, e.c, e.t, e.d, e.m);
                end
            end
        end
    end

    initial begin
        logic [7:0] w1[8];
        logic [7:0] w2[5];
        logic [7:0] w3[4];
        w1 = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
        w2 = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1};
        w3 = '{8'd2, 8'd2, 8'd2, 8'd3};
        rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.load_val = 8'h00; bus.dir = 1'b1;
        bus.mode = 2'b00; bus.limit = 8'd5; bus.presc = 4'd0; bus.cmp_val = 8'hEE; bus.oe = 1'b1;
        chk("reset", 8'h00, 0, 0, 0);
        rst = 1'b0; bus.en = 1'b1;
        for (int i = 0; i < 8; i++) chk("wrap_up", w1[i], i == 5, 0, 0);
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h00;
        chk("load0", 8'h00, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.presc = 4'd2;
        for (int i = 0; i < 5; i++) chk("presc2", w2[i], 0, 0, 0);
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) chk("en_freeze", 8'd1, 0, 0, 0);
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) chk("presc2_resume", w3[i], 0, 0, 0);
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'd2; bus.presc = 4'd0;
        chk("sat_load", 8'd2, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1; bus.mode = 2'b01; bus.dir = 1'b0;
        chk("sat_dn1", 8'd1, 0, 0, 0);
        chk("sat_dn0", 8'd0, 0, 0, 0);
        chk("sat_hold_a", 8'd0, 1, 0, 0);
        chk("sat_hold_b", 8'd0, 1, 0, 0);
        bus.oe = 1'b0; bus.cmp_val = 8'h00;
        chk("sat_oe_off", 8'd0, 1, 0, 1);
        bus.oe = 1'b1; bus.en = 1'b0; bus.cmp_val = 8'hEE;
        chk("sat_no_tick", 8'd0, 0, 0, 0);
        bus.load = 1'b1; bus.load_val = 8'd0; bus.mode = 2'b10; bus.dir = 1'b1; bus.limit = 8'd3;
        chk("os_load", 8'd0, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1;
        chk("os_1", 8'd1, 0, 0, 0);
        chk("os_2", 8'd2, 0, 0, 0);
        chk("os_3", 8'd3, 0, 0, 0);
        chk("os_term", 8'd3, 1, 1, 0);
        chk("os_done_a", 8'd3, 0, 1, 0);
        chk("os_done_b", 8'd3, 0, 1, 0);
        bus.load = 1'b1; bus.load_val = 8'd1;
        chk("os_reload", 8'd1, 0, 0, 0);
        bus.load = 1'b0;
        chk("os2_2", 8'd2, 0, 0, 0);
        chk("os2_3", 8'd3, 0, 0, 0);
        chk("os2_term", 8'd3, 1, 1, 0);
        bus.mode = 2'b00;
        chk("done_exit", 8'd3, 0, 0, 0);
        chk("exit_wrap", 8'd0, 1, 0, 0);
        bus.limit = 8'd5; bus.presc = 4'd1;
        chk("pcnt_1", 8'd0, 0, 0, 0);
        bus.load = 1'b1; bus.load_val = 8'hAA; bus.cmp_val = 8'hAA;
        chk("load_vs_tick", 8'h00 | 8'hAA, 0, 0, 1);
        bus.load = 1'b0; bus.oe = 1'b0;
        chk("pcnt_cleared", 8'h00, 0, 0, 1);
        bus.oe = 1'b1;
        chk("limit_below", 8'h00, 1, 0, 0);
        bus.mode = 2'b10; bus.limit = 8'h40; bus.presc = 4'd0; bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h40;
        chk("load40", 8'h40, 0, 0, 0);
        bus.load = 1'b0; bus.en = 1'b1;
        chk("os40_term", 8'h40, 1, 1, 0);
        rst = 1'b1; bus.load = 1'b1; bus.load_val = 8'h77;
        chk("rst_beats_load", 8'h00, 0, 0, 0);
        rst = 1'b0; bus.load = 1'b0; bus.mode = 2'b00; bus.dir = 1'b0; bus.limit = 8'd0;
        chk("lim0_dn_a", 8'd0, 1, 0, 0);
        chk("lim0_dn_b", 8'd0, 1, 0, 0);
        bus.dir = 1'b1;
        chk("lim0_up", 8'd0, 1, 0, 0);
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        #5;
        if (q.size() > 0) begin
            miss++;
            $display("FAIL drain: %0d vectors left, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
